// File: rtl/bram_port_master.sv
// rtl/bram_port_master.sv - request/response front end for one BRAM port with a zero-fill sweep
module bram_port_master #(
   parameter int DATA_W = 2,
   parameter int ADDR_W = 13
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              REQ_VALID,
   output logic              REQ_READY,
   input  logic              REQ_WE,
   input  logic [ADDR_W-1:0] REQ_ADDR,
   input  logic [DATA_W-1:0] REQ_WDATA,
   output logic              RSP_VALID,
   input  logic              RSP_READY,
   output logic [DATA_W-1:0] RSP_RDATA,
   input  logic              CLR_START,
   output logic              BUSY,
   output logic              CLR_DONE,
   output logic              EN,
   output logic              WE,
   output logic              SSR,
   output logic [ADDR_W-1:0] ADDR,
   output logic [DATA_W-1:0] DI,
   input  logic [DATA_W-1:0] DO
);

   typedef enum logic {
      ST_IDLE,
      ST_CLEAR
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] clr_cnt;
   logic              inflight;
   logic [DATA_W-1:0] fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_cnt;
   logic [1:0]        occupancy;
   logic              xfer;
   logic              push;
   logic              pop;

   // Buffered plus in-flight reads may never exceed the two FIFO slots.
   assign occupancy = fifo_cnt + {1'b0, inflight};
   assign REQ_READY = (state == ST_IDLE) && !CLR_START && (occupancy < 2'd2);
   assign xfer      = REQ_VALID & REQ_READY;

   assign push      = inflight;
   assign RSP_VALID = (fifo_cnt != 2'd0);
   assign RSP_RDATA = fifo_mem[rd_ptr];
   assign pop       = RSP_VALID & RSP_READY;

   assign BUSY = (state == ST_CLEAR);
   assign SSR  = ~RST_N;

   always_comb begin
      state_nxt = state;
      EN        = 1'b0;
      WE        = 1'b0;
      ADDR      = '0;
      DI        = '0;
      CLR_DONE  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (xfer) begin
               EN   = 1'b1;
               WE   = REQ_WE;
               ADDR = REQ_ADDR;
               DI   = REQ_WDATA;
            end
            if (CLR_START) begin
               state_nxt = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            EN   = 1'b1;
            WE   = 1'b1;
            ADDR = clr_cnt;
            if (clr_cnt == LAST_ADDR) begin
               CLR_DONE  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= ST_IDLE;
         clr_cnt  <= '0;
         inflight <= 1'b0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         state <= state_nxt;
         if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
         end else begin
            clr_cnt <= '0;
         end
         inflight <= xfer & ~REQ_WE;
         if (push) begin
            wr_ptr <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // Storage needs no reset; occupancy is tracked by fifo_cnt.
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem[wr_ptr] <= DO;
      end
   end

endmodule

// File: tb/tb_bram_port_master.sv
// tb/tb_bram_port_master.sv - directed self-checking bench for bram_port_master
module tb_bram_port_master;

   localparam int DATA_W = 2;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic              CLK;
   logic              RST_N;
   logic              REQ_VALID;
   logic              REQ_READY;
   logic              REQ_WE;
   logic [ADDR_W-1:0] REQ_ADDR;
   logic [DATA_W-1:0] REQ_WDATA;
   logic              RSP_VALID;
   logic              RSP_READY;
   logic [DATA_W-1:0] RSP_RDATA;
   logic              CLR_START;
   logic              BUSY;
   logic              CLR_DONE;
   logic              EN;
   logic              WE;
   logic              SSR;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] DI;
   logic [DATA_W-1:0] DO;

   int checks;
   int errors;

   logic [DATA_W-1:0] bram [DEPTH];
   logic [DATA_W-1:0] shadow [DEPTH];
   logic [ADDR_W-1:0] rd_addr [128];

   bram_port_master #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .REQ_VALID(REQ_VALID),
      .REQ_READY(REQ_READY),
      .REQ_WE   (REQ_WE),
      .REQ_ADDR (REQ_ADDR),
      .REQ_WDATA(REQ_WDATA),
      .RSP_VALID(RSP_VALID),
      .RSP_READY(RSP_READY),
      .RSP_RDATA(RSP_RDATA),
      .CLR_START(CLR_START),
      .BUSY     (BUSY),
      .CLR_DONE (CLR_DONE),
      .EN       (EN),
      .WE       (WE),
      .SSR      (SSR),
      .ADDR     (ADDR),
      .DI       (DI),
      .DO       (DO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Read-first block RAM with one cycle of registered read latency.
   initial begin
      for (int i = 0; i < DEPTH; i++) bram[i] = '0;
      DO = '0;
   end

   always @(posedge CLK) begin
      if (SSR) begin
         DO <= '0;
      end else if (EN) begin
         if (WE) bram[ADDR] <= DI;
         DO <= bram[ADDR];
      end
   end

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      int t;
      t = 0;
      @(posedge CLK); #1;
      REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = a; REQ_WDATA = d;
      #1;
      while (!REQ_READY && t < 20) begin
         @(posedge CLK); #2;
         t++;
      end
      checks++;
      if (REQ_READY !== 1'b1) begin
         errors++;
         $display("FAIL write_accept addr %0d: REQ_READY=%b required 1", a, REQ_READY);
      end
      @(posedge CLK); #1;
      REQ_VALID = 1'b0; REQ_WE = 1'b0;
      shadow[a] = d;
   endtask

   task automatic run_reads(input int n);
      int issued;
      int got;
      int cyc;
      logic [DATA_W-1:0] exp_q[$];
      issued = 0; got = 0; cyc = 0;
      RSP_READY = 1'b1;
      REQ_WE = 1'b0;
      while ((issued < n || got < n) && cyc < 2000) begin
         @(posedge CLK); #1;
         REQ_VALID = (issued < n);
         REQ_ADDR  = rd_addr[issued];
         #1;
         if (RSP_VALID) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rd_spurious: RSP_RDATA=%0h with nothing outstanding", RSP_RDATA);
            end else begin
               if (RSP_RDATA !== exp_q[0]) begin
                  errors++;
                  $display("FAIL rd_data #%0d: RSP_RDATA=%0h required %0h", got, RSP_RDATA, exp_q[0]);
               end
               void'(exp_q.pop_front());
               got++;
            end
         end
         if (REQ_VALID && REQ_READY) begin
            exp_q.push_back(shadow[rd_addr[issued]]);
            issued++;
         end
         cyc++;
      end
      REQ_VALID = 1'b0;
      checks++;
      if (got !== n) begin
         errors++;
         $display("FAIL rd_count: received %0d responses required %0d", got, n);
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: %b required 0", RSP_VALID); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: %b required 0", BUSY); end
      checks++; if (CLR_DONE !== 1'b0) begin errors++; $display("FAIL rst_clr_done: %b required 0", CLR_DONE); end
      checks++; if (EN !== 1'b0 || WE !== 1'b0) begin errors++; $display("FAIL rst_en_we: EN=%b WE=%b required 0 0", EN, WE); end
      checks++; if (SSR !== 1'b1) begin errors++; $display("FAIL rst_ssr: %b required 1", SSR); end
      RST_N = 1'b1;
      #1;
      checks++; if (SSR !== 1'b0) begin errors++; $display("FAIL run_ssr: %b required 0", SSR); end
      checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL run_ready: %b required 1", REQ_READY); end
   endtask

   task automatic test_write_read();
      RSP_READY = 1'b1;
      @(posedge CLK); #1;
      REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 4'd5; REQ_WDATA = 2'b10;
      #1;
      checks++;
      if (EN !== 1'b1 || WE !== 1'b1 || ADDR !== 4'd5 || DI !== 2'b10) begin
         errors++;
         $display("FAIL wr_drive: EN=%b WE=%b ADDR=%0d DI=%0h required 1 1 5 2", EN, WE, ADDR, DI);
      end
      shadow[5] = 2'b10;
      @(posedge CLK); #1;
      REQ_WE = 1'b0;
      #1;
      checks++;
      if (REQ_READY !== 1'b1 || EN !== 1'b1 || WE !== 1'b0 || ADDR !== 4'd5) begin
         errors++;
         $display("FAIL rd_drive: READY=%b EN=%b WE=%b ADDR=%0d required 1 1 0 5", REQ_READY, EN, WE, ADDR);
      end
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      #1;
      checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL rd_lat1: RSP_VALID=%b required 0", RSP_VALID); end
      @(posedge CLK); #2;
      checks++; if (RSP_VALID !== 1'b1) begin errors++; $display("FAIL rd_lat2: RSP_VALID=%b required 1", RSP_VALID); end
      checks++; if (RSP_RDATA !== 2'b10) begin errors++; $display("FAIL rd_data5: RSP_RDATA=%0h required 2", RSP_RDATA); end
      @(posedge CLK); #2;
      checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL rd_pop: RSP_VALID=%b required 0", RSP_VALID); end
   endtask

   task automatic test_backpressure();
      do_write(4'd1, 2'b01);
      do_write(4'd2, 2'b10);
      do_write(4'd3, 2'b11);
      RSP_READY = 1'b0; REQ_WE = 1'b0;
      @(posedge CLK); #1;
      REQ_VALID = 1'b1; REQ_ADDR = 4'd1;
      #1;
      checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL bp_acc1: REQ_READY=%b required 1", REQ_READY); end
      @(posedge CLK); #1;
      REQ_ADDR = 4'd2;
      #1;
      checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL bp_acc2: REQ_READY=%b required 1", REQ_READY); end
      @(posedge CLK); #1;
      REQ_ADDR = 4'd3;
      #1;
      checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL bp_block3: REQ_READY=%b required 0", REQ_READY); end
      checks++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== 2'b01) begin errors++; $display("FAIL bp_head1: VALID=%b DATA=%0h required 1 1", RSP_VALID, RSP_RDATA); end
      @(posedge CLK); #2;
      checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL bp_full: REQ_READY=%b required 0", REQ_READY); end
      @(posedge CLK); #1;
      RSP_READY = 1'b1;
      #1;
      checks++; if (REQ_READY !== 1'b0 || RSP_RDATA !== 2'b01) begin errors++; $display("FAIL bp_drain1: READY=%b DATA=%0h required 0 1", REQ_READY, RSP_RDATA); end
      @(posedge CLK); #2;
      checks++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== 2'b10) begin errors++; $display("FAIL bp_drain2: VALID=%b DATA=%0h required 1 2", RSP_VALID, RSP_RDATA); end
      checks++; if (REQ_READY !== 1'b1) begin errors++; $display("FAIL bp_acc3: REQ_READY=%b required 1", REQ_READY); end
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      #1;
      checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL bp_gap: RSP_VALID=%b required 0", RSP_VALID); end
      @(posedge CLK); #2;
      checks++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== 2'b11) begin errors++; $display("FAIL bp_data3: VALID=%b DATA=%0h required 1 3", RSP_VALID, RSP_RDATA); end
      @(posedge CLK); #2;
      checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL bp_empty: RSP_VALID=%b required 0", RSP_VALID); end
   endtask

   task automatic test_clear();
      for (int i = 0; i < DEPTH; i++) do_write(4'(i), 2'b11);
      @(posedge CLK); #1;
      CLR_START = 1'b1;
      #1;
      checks++; if (REQ_READY !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL clr_start: READY=%b BUSY=%b required 0 0", REQ_READY, BUSY); end
      @(posedge CLK); #1;
      CLR_START = 1'b0;
      #1;
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (BUSY !== 1'b1 || EN !== 1'b1 || WE !== 1'b1 || DI !== 2'b00 || ADDR !== 4'(i)
             || CLR_DONE !== (i == DEPTH - 1)) begin
            errors++;
            $display("FAIL clr_cycle %0d: BUSY=%b EN=%b WE=%b DI=%0h ADDR=%0d DONE=%b required 1 1 1 0 %0d %b",
                     i, BUSY, EN, WE, DI, ADDR, CLR_DONE, i, (i == DEPTH - 1));
         end
         @(posedge CLK); #2;
      end
      checks++; if (BUSY !== 1'b0 || CLR_DONE !== 1'b0) begin errors++; $display("FAIL clr_end: BUSY=%b DONE=%b required 0 0", BUSY, CLR_DONE); end
      for (int i = 0; i < DEPTH; i++) begin
         shadow[i] = '0;
         rd_addr[i] = 4'(i);
      end
      run_reads(DEPTH);
   endtask

   task automatic test_clr_vs_req();
      logic ready_seen;
      logic busy_fell;
      ready_seen = 1'b0; busy_fell = 1'b0;
      @(posedge CLK); #1;
      CLR_START = 1'b1; REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_ADDR = 4'd3; REQ_WDATA = 2'b01;
      #1;
      checks++; if (REQ_READY !== 1'b0) begin errors++; $display("FAIL cvr_ready: REQ_READY=%b required 0", REQ_READY); end
      @(posedge CLK); #1;
      CLR_START = 1'b0;
      for (int t = 0; t < 40; t++) begin
         #1;
         if (!BUSY) begin
            busy_fell = 1'b1;
            break;
         end
         if (REQ_READY) ready_seen = 1'b1;
         @(posedge CLK); #1;
      end
      checks++; if (busy_fell !== 1'b1) begin errors++; $display("FAIL cvr_timeout: BUSY never fell"); end
      checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL cvr_ready_busy: REQ_READY seen during sweep"); end
      checks++;
      if (REQ_READY !== 1'b1 || EN !== 1'b1 || WE !== 1'b1 || ADDR !== 4'd3) begin
         errors++;
         $display("FAIL cvr_accept: READY=%b EN=%b WE=%b ADDR=%0d required 1 1 1 3", REQ_READY, EN, WE, ADDR);
      end
      @(posedge CLK); #1;
      REQ_VALID = 1'b0; REQ_WE = 1'b0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
      shadow[3] = 2'b01;
      rd_addr[0] = 4'd2; rd_addr[1] = 4'd3; rd_addr[2] = 4'd4;
      run_reads(3);
   endtask

   task automatic test_reset_mid_sweep();
      logic found;
      logic done_seen;
      found = 1'b0; done_seen = 1'b0;
      RSP_READY = 1'b0;
      @(posedge CLK); #1;
      REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 4'd3;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0; CLR_START = 1'b1;
      @(posedge CLK); #1;
      CLR_START = 1'b0;
      for (int t = 0; t < 30; t++) begin
         #1;
         if (BUSY && ADDR == 4'd7) begin
            found = 1'b1;
            break;
         end
         @(posedge CLK); #1;
      end
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL rms_timeout: sweep addr 7 not reached"); end
      checks++; if (RSP_VALID !== 1'b1) begin errors++; $display("FAIL rms_buffered: RSP_VALID=%b required 1", RSP_VALID); end
      RST_N = 1'b0;
      #1;
      checks++; if (SSR !== 1'b1) begin errors++; $display("FAIL rms_ssr_now: SSR=%b required 1", SSR); end
      @(posedge CLK); #2;
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rms_busy: BUSY=%b required 0", BUSY); end
      checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL rms_rsp: RSP_VALID=%b required 0", RSP_VALID); end
      checks++; if (SSR !== 1'b1 || CLR_DONE !== 1'b0 || EN !== 1'b0) begin errors++; $display("FAIL rms_out: SSR=%b DONE=%b EN=%b required 1 0 0", SSR, CLR_DONE, EN); end
      RST_N = 1'b1;
      for (int t = 0; t < 20; t++) begin
         @(posedge CLK); #2;
         if (CLR_DONE || BUSY || RSP_VALID) done_seen = 1'b1;
      end
      checks++; if (done_seen !== 1'b0) begin errors++; $display("FAIL rms_after: sweep or response resumed after reset"); end
   endtask

   task automatic test_stream();
      for (int i = 0; i < DEPTH; i++) do_write(4'(i), 2'((i * 3 + 1) & 3));
      for (int i = 0; i < 100; i++) rd_addr[i] = 4'($urandom_range(0, DEPTH - 1));
      run_reads(100);
   endtask

   initial begin
      checks = 0; errors = 0;
      RST_N = 1'b0; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = '0; REQ_WDATA = '0;
      RSP_READY = 1'b0; CLR_START = 1'b0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
      for (int i = 0; i < 128; i++) rd_addr[i] = '0;
      test_reset();
      test_write_read();
      test_backpressure();
      test_clear();
      test_clr_vs_req();
      test_reset_mid_sweep();
      test_stream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
